// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
//   - Opcode constants for the instruction classes the FSM understands.
//   - ALUOp and memToReg (write-back select) encodings.
//   - FSM state enumeration.
//   - Helper that identifies states which stall on the memory handshake.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_ADDR   = 4'd5,
    S_MEMRD  = 4'd6,
    S_LDWB   = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  // States that wait on mem_ready and are therefore watched by the watchdog.
  function automatic logic is_mem_state(input state_t st);
    case (st)
      S_FETCH, S_MEMRD, S_MEMWR: is_mem_state = 1'b1;
      default:                   is_mem_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory,
// with a mem_ready handshake, a memory-stall watchdog, sticky illegal-opcode
// and bus-error traps, and a retired-instruction counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   opcode     instr[6:0] from the IR (valid from the cycle after ir_write)
//   mem_ready  memory completes the current access this cycle
//   pc_write, ir_write, i_or_d, memRead, memWrite, ALUSrc, ALUOp, branch,
//   regWrite, memToReg   datapath control strobes (decoded from state)
//   illegal    sticky: unknown opcode decoded
//   bus_err    sticky: memory watchdog expired
//   instret    count of retired instructions (wraps)
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int EN_JAL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             memRead,
  output logic             memWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             branch,
  output logic             regWrite,
  output logic [1:0]       memToReg,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic              JAL_OK     = (EN_JAL != 0);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic                is_imm_q, is_imm_d;   // decoded class: I-arith vs R-type
  logic                is_load_q, is_load_d; // decoded class: load vs store
  logic                wd_expire_s;

  // Watchdog fires when a watched access is still stalled at the limit;
  // a mem_ready arriving on that same cycle takes priority.
  assign wd_expire_s = is_mem_state(state_q) && !mem_ready && (wait_cnt_q == MAX_WAIT_C);

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      instret_q  <= '0;
      is_imm_q   <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      instret_q  <= instret_d;
      is_imm_q   <= is_imm_d;
      is_load_q  <= is_load_d;
    end
  end

  // Watchdog counter: counts stalled cycles, clears on completion or exit.
  always_comb begin
    wait_cnt_d = '0;
    if (is_mem_state(state_q) && !mem_ready && !wd_expire_s) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Next-state, trap flags, retire counter and control-strobe decode.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    instret_d = instret_q;
    is_imm_d  = is_imm_q;
    is_load_d = is_load_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALUOP_ADD;
    branch    = 1'b0;
    regWrite  = 1'b0;
    memToReg  = WB_ALU;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        memRead = 1'b1;
        i_or_d  = 1'b0;
        if (mem_ready) begin
          // IR load and PC+4 happen in the completing cycle itself.
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expire_s) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R: begin
            is_imm_d = 1'b0;
            state_d  = S_EXEC;
          end
          OP_I: begin
            is_imm_d = 1'b1;
            state_d  = S_EXEC;
          end
          OP_LOAD: begin
            is_load_d = 1'b1;
            state_d   = S_ADDR;
          end
          OP_STORE: begin
            is_load_d = 1'b0;
            state_d   = S_ADDR;
          end
          OP_BRANCH: begin
            state_d = S_BRANCH;
          end
          OP_JAL: begin
            if (JAL_OK) begin
              state_d = S_JUMP;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_TRAP;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        ALUOp   = ALUOP_FUNCT;
        ALUSrc  = is_imm_q;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        memToReg  = WB_ALU;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        ALUOp   = ALUOP_ADD;
        state_d = is_load_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = S_LDWB;
        end else if (wd_expire_s) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_LDWB: begin
        regWrite  = 1'b1;
        memToReg  = WB_MEM;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          // A store retires when its write completes.
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (wd_expire_s) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_BRANCH: begin
        ALUOp     = ALUOP_BR;
        branch    = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        regWrite  = 1'b1;
        memToReg  = WB_PC4;
        pc_write  = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        // Parked with all strobes low; only rst leaves this state.
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each cycle the expected control vector
// is queued as stimulus is applied and popped/compared on the falling edge.
module tb_multicycle_control_unit;
  import rv_ctrl_pkg::*;

  // Control vector: {pc_write, ir_write, i_or_d, memRead, memWrite, ALUSrc,
  //                  ALUOp[1:0], branch, regWrite, memToReg[1:0]}
  localparam logic [11:0] E_NONE  = 12'h000;
  localparam logic [11:0] E_FST   = 12'h100; // fetch stalled
  localparam logic [11:0] E_FDONE = 12'hD00; // fetch completing
  localparam logic [11:0] E_EXR   = 12'h020;
  localparam logic [11:0] E_EXI   = 12'h060;
  localparam logic [11:0] E_ALUWB = 12'h004;
  localparam logic [11:0] E_ADDR  = 12'h040;
  localparam logic [11:0] E_MEMRD = 12'h300;
  localparam logic [11:0] E_LDWB  = 12'h005;
  localparam logic [11:0] E_MEMWR = 12'h280;
  localparam logic [11:0] E_BR    = 12'h018;
  localparam logic [11:0] E_JUMP  = 12'h806;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, i_or_d, memRead, memWrite, ALUSrc, branch, regWrite;
  logic [1:0]  ALUOp, memToReg;
  logic        illegal, bus_err;
  logic [31:0] instret;

  logic        nj_pc_write, nj_ir_write, nj_i_or_d, nj_memRead, nj_memWrite, nj_ALUSrc;
  logic        nj_branch, nj_regWrite;
  logic [1:0]  nj_ALUOp, nj_memToReg;
  logic        nj_illegal, nj_bus_err;
  logic [31:0] nj_instret;

  logic [11:0] vec, nj_vec;
  assign vec    = {pc_write, ir_write, i_or_d, memRead, memWrite, ALUSrc,
                   ALUOp, branch, regWrite, memToReg};
  assign nj_vec = {nj_pc_write, nj_ir_write, nj_i_or_d, nj_memRead, nj_memWrite, nj_ALUSrc,
                   nj_ALUOp, nj_branch, nj_regWrite, nj_memToReg};

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.CNT_W(32), .WAIT_W(4), .MAX_WAIT(15), .EN_JAL(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .memRead(memRead),
    .memWrite(memWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .branch(branch),
    .regWrite(regWrite), .memToReg(memToReg), .illegal(illegal), .bus_err(bus_err),
    .instret(instret)
  );

  multicycle_control_unit #(.CNT_W(32), .WAIT_W(4), .MAX_WAIT(15), .EN_JAL(0)) dut_nojal (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(nj_pc_write), .ir_write(nj_ir_write), .i_or_d(nj_i_or_d), .memRead(nj_memRead),
    .memWrite(nj_memWrite), .ALUSrc(nj_ALUSrc), .ALUOp(nj_ALUOp), .branch(nj_branch),
    .regWrite(nj_regWrite), .memToReg(nj_memToReg), .illegal(nj_illegal), .bus_err(nj_bus_err),
    .instret(nj_instret)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: apply inputs after the edge, queue the expectation,
  // then compare the control vector on the falling edge.
  task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                     input logic rdy, input logic [11:0] e);
    logic [11:0] want;
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    chk(tag, 32'(vec), 32'(want));
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset held: everything low, counters clear.
    cyc("rst0", 1'b1, 7'd0, 1'b0, E_NONE);
    cyc("rst1", 1'b1, 7'd0, 1'b0, E_NONE);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_nj_vec", 32'(nj_vec), 32'd0);
    chk("rst_nj_flags", {nj_instret[29:0], nj_illegal, nj_bus_err}, 32'd0);
    cyc("s_rst", 1'b0, 7'd0, 1'b1, E_NONE);

    // R-type add.
    cyc("add_fetch", 1'b0, OP_R, 1'b1, E_FDONE);
    cyc("add_dec",   1'b0, OP_R, 1'b1, E_NONE);
    cyc("add_exec",  1'b0, OP_R, 1'b1, E_EXR);
    cyc("add_wb",    1'b0, OP_R, 1'b1, E_ALUWB);

    // I-arith addi.
    cyc("addi_fetch", 1'b0, OP_I, 1'b1, E_FDONE);
    chk("instret_add", instret, 32'd1);
    cyc("addi_dec",   1'b0, OP_I, 1'b1, E_NONE);
    cyc("addi_exec",  1'b0, OP_I, 1'b1, E_EXI);
    cyc("addi_wb",    1'b0, OP_I, 1'b1, E_ALUWB);

    // Load with three wait cycles.
    cyc("lw_fetch", 1'b0, OP_LOAD, 1'b1, E_FDONE);
    chk("instret_addi", instret, 32'd2);
    cyc("lw_dec",   1'b0, OP_LOAD, 1'b1, E_NONE);
    cyc("lw_addr",  1'b0, OP_LOAD, 1'b1, E_ADDR);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, OP_LOAD, 1'b0, E_MEMRD);
    cyc("lw_memrd_done", 1'b0, OP_LOAD, 1'b1, E_MEMRD);
    cyc("lw_wb",    1'b0, OP_LOAD, 1'b1, E_LDWB);

    // Store then branch.
    cyc("sw_fetch", 1'b0, OP_STORE, 1'b1, E_FDONE);
    chk("instret_lw", instret, 32'd3);
    cyc("sw_dec",   1'b0, OP_STORE, 1'b1, E_NONE);
    cyc("sw_addr",  1'b0, OP_STORE, 1'b1, E_ADDR);
    cyc("sw_memwr", 1'b0, OP_STORE, 1'b1, E_MEMWR);
    cyc("beq_fetch", 1'b0, OP_BRANCH, 1'b1, E_FDONE);
    chk("instret_sw", instret, 32'd4);
    cyc("beq_dec",  1'b0, OP_BRANCH, 1'b1, E_NONE);
    cyc("beq_br",   1'b0, OP_BRANCH, 1'b1, E_BR);

    // JAL: legal on the main instance, illegal when JAL is disabled.
    cyc("jal_fetch", 1'b0, OP_JAL, 1'b1, E_FDONE);
    chk("instret_beq", instret, 32'd5);
    cyc("jal_dec",  1'b0, OP_JAL, 1'b1, E_NONE);
    cyc("jal_jump", 1'b0, OP_JAL, 1'b1, E_JUMP);
    chk("jal_illegal_main", 32'(illegal), 32'd0);
    chk("jal_illegal_nojal", 32'(nj_illegal), 32'd1);

    // Unknown opcode traps and stays parked.
    cyc("ill_fetch", 1'b0, 7'h7F, 1'b1, E_FDONE);
    chk("instret_jal", instret, 32'd6);
    cyc("ill_dec",  1'b0, 7'h7F, 1'b1, E_NONE);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 1'b0, 7'h7F, 1'b1, E_NONE);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_instret", instret, 32'd6);
    chk("ill_bus_err", 32'(bus_err), 32'd0);
    cyc("ill_rst", 1'b1, 7'd0, 1'b1, E_NONE);
    cyc("ill_srst", 1'b0, 7'd0, 1'b0, E_NONE);
    chk("ill_cleared", 32'(illegal), 32'd0);
    chk("ill_instret_clr", instret, 32'd0);
    chk("nj_ill_cleared", 32'(nj_illegal), 32'd0);

    // Ready arriving when the stall count hits the limit: no error.
    for (int i = 0; i < 15; i++) cyc("wd_stall_ok", 1'b0, OP_BRANCH, 1'b0, E_FST);
    cyc("wd_edge_ready", 1'b0, OP_BRANCH, 1'b1, E_FDONE);
    chk("wd_no_err", 32'(bus_err), 32'd0);
    cyc("wd_dec", 1'b0, OP_BRANCH, 1'b1, E_NONE);
    cyc("wd_br",  1'b0, OP_BRANCH, 1'b1, E_BR);

    // One more stalled cycle than that: bus error trap.
    for (int i = 0; i < 16; i++) cyc("wd_stall_err", 1'b0, OP_R, 1'b0, E_FST);
    cyc("wd_trap", 1'b0, OP_R, 1'b0, E_NONE);
    chk("wd_bus_err", 32'(bus_err), 32'd1);
    chk("wd_illegal", 32'(illegal), 32'd0);
    chk("wd_instret", instret, 32'd1);
    cyc("wd_trap_hold", 1'b0, OP_R, 1'b1, E_NONE);
    chk("wd_bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset mid-store: no memWrite after reset is applied.
    cyc("mr_rst",   1'b1, OP_STORE, 1'b1, E_NONE);
    cyc("mr_srst",  1'b0, OP_STORE, 1'b1, E_NONE);
    chk("mr_bus_err_clr", 32'(bus_err), 32'd0);
    cyc("mr_fetch", 1'b0, OP_STORE, 1'b1, E_FDONE);
    cyc("mr_dec",   1'b0, OP_STORE, 1'b1, E_NONE);
    cyc("mr_addr_rst", 1'b1, OP_STORE, 1'b1, E_ADDR);
    cyc("mr_after_rst", 1'b0, OP_STORE, 1'b1, E_NONE);
    cyc("mr_refetch", 1'b0, OP_R, 1'b1, E_FDONE);
    chk("mr_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
